time_of_day_counter: RTL and testbench
======================================

Name: time_of_day_counter

Overview:
Parametrised hours/minutes/seconds time-of-day counter, the successor to the single-field hours counter. It holds the full time in one block with a built-in seconds prescaler, runtime 12/24-hour display mode, per-field set with increment/decrement, and a day-rollover pulse. It sits between the board clock divider and the seven-segment display driver of the digital clock design.

Parameters:
TICKS_PER_SEC, 1, seconds_clk cycles per one-second advance; legal range 1..2^24.
RESET_HOUR24, 0, internal hour loaded at reset, 0..23; 0 displays as 12 AM in 12h mode.
RESET_MINUTE, 0, minute loaded at reset, 0..59.
RESET_SECOND, 0, second loaded at reset, 0..59.

Ports:
seconds_clk  input  1  single clock; all state changes on its rising edge.
rst  input  1  asynchronous, active-low reset.
mode_24h  input  1  display mode: 1 = 24h (0..23), 0 = 12h (1..12 plus pm).
set_mode  input  2  00 run, 01 set hours, 10 set minutes, 11 set seconds.
inc  input  1  level sampled each cycle; in set mode, +1 to the selected field.
dec  input  1  level sampled each cycle; in set mode, -1 to the selected field.
hours  output  5  displayed hour.
minutes  output  6  minute, 0..59.
seconds  output  6  second, 0..59.
pm  output  1  1 when hour24 >= 12, in either mode.
day_pulse  output  1  one-cycle pulse on the 23:59:59 -> 00:00:00 run-mode rollover.

Behaviour:
- State registers: hour24 (5b, 0..23), min (6b), sec (6b), presc (ceil(log2(TICKS_PER_SEC)) bits, minimum 1), day_pulse register.
- Reset (rst low, asynchronous): hour24/min/sec take the RESET_* values, presc=0, day_pulse=0. Reset mid-count discards any partial prescale.
- Output decode is combinational from registers, so a mode_24h change is visible in the same cycle.
  - 24h: hours=hour24.
  - 12h: hours=12 if hour24 mod 12 == 0, else hour24 mod 12.
- Run (set_mode=00):
  - presc increments each cycle. At TICKS_PER_SEC-1 it returns to 0 and a second tick fires. With TICKS_PER_SEC=1, every cycle is a tick.
  - On a tick: sec+1. At 59, sec wraps to 0 and carries to min. min 59->0 carries to hour24. hour24 23->0.
  - The full 23:59:59 wrap also sets day_pulse=1 for exactly the next cycle. day_pulse is 0 at all other times.
  - inc/dec are ignored.
- Set modes (01/10/11):
  - presc is held at 0 and time does not advance. day_pulse stays 0.
  - inc alone: selected field +1 with wrap (hour 23->0, min/sec 59->0). There is no carry into any other field.
  - dec alone: selected field -1 with wrap (0->23 or 0->59).
  - inc and dec together: no change.
  - inc held for N cycles steps the field N times. Debouncing and edge detection are external.
  - In 12h mode, hour stepping moves hour24, so 11 AM +1 -> 12 PM and 12 AM -1 -> 11 PM.
- Set -> run transition: counting resumes with presc=0, so the first tick occurs TICKS_PER_SEC cycles after the first run cycle.
- Changing set_mode between two set fields has no side effect.
- A run-mode tick and a set_mode change in the same cycle: set_mode is sampled that cycle and takes precedence. A set value suppresses the tick.

Optional Feature:
Macro TIME_ALARM_EN.
- When defined, the block adds:
  - Inputs: alarm_load (1), alarm_hour24_in (5), alarm_minute_in (6), alarm_arm (1).
  - Output: alarm_ring (1).
- alarm_load=1 captures alarm_hour24_in and alarm_minute_in into alarm registers. Out-of-range values are clamped to 23/59. Reset values are 0:00.
- alarm_ring sets on the cycle after a run-mode tick produces hour24:min:sec == alarm_h:alarm_m:00 while alarm_arm=1.
- alarm_ring then holds until alarm_arm=0 (clears the next cycle) or reset. Reset clears alarm_ring.
- Reaching the alarm time through set-mode edits never sets alarm_ring.
- When undefined, these ports and all alarm logic are absent. All other behaviour is identical.

Test Plan:
1. Reset defaults, mode_24h=0, release rst -> hours=12, minutes=0, seconds=0, pm=0. Assert rst mid-run -> all return to reset values immediately, without waiting for a clock edge.
2. RESET_HOUR24=23, RESET_MINUTE=59, RESET_SECOND=59, TICKS_PER_SEC=1, run one cycle -> 00:00:00, day_pulse high exactly one cycle, pm=0.
3. Run from 11:59:59 -> after one tick hour24=12; mode_24h=0 gives hours=12, pm=1; toggle mode_24h=1 -> hours=12 in the same cycle; hour24=13 -> hours=1 (12h) and 13 (24h).
4. set_mode=10, min=59, inc 1 cycle -> min=0, hour unchanged. dec 1 cycle -> 59. inc and dec together -> 59 held. Time frozen throughout.
5. TICKS_PER_SEC=4: sec advances every 4th cycle. Enter set mode at presc=2, return to run -> next advance exactly 4 cycles later.
6. TIME_ALARM_EN: load alarm 7:30, arm, run from 07:29:58 -> alarm_ring rises the cycle after 07:30:00. Drop alarm_arm -> clears the next cycle. Set-editing the time to 07:30:00 -> no ring.

Source files
------------

// File: rtl/time_of_day_counter.sv
// Hours/minutes/seconds time-of-day counter with seconds prescaler, 12/24h decode,
// per-field set/inc/dec and day rollover pulse. Optional alarm enabled by TIME_ALARM_EN.
module time_of_day_counter #(
    parameter int TICKS_PER_SEC = 1,
    parameter int RESET_HOUR24  = 0,
    parameter int RESET_MINUTE  = 0,
    parameter int RESET_SECOND  = 0
) (
    input  logic       seconds_clk,
    input  logic       rst,
    input  logic       mode_24h,
    input  logic [1:0] set_mode,
    input  logic       inc,
    input  logic       dec,
`ifdef TIME_ALARM_EN
    input  logic       alarm_load,
    input  logic [4:0] alarm_hour24_in,
    input  logic [5:0] alarm_minute_in,
    input  logic       alarm_arm,
    output logic       alarm_ring,
`endif
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       pm,
    output logic       day_pulse
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

    logic [4:0]    hour24_q, hour24_d;
    logic [5:0]    min_q, min_d;
    logic [5:0]    sec_q, sec_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          day_pulse_q, day_pulse_d;
    logic          tick;
    logic          step_up, step_dn;
    logic [4:0]    hour_mod12;

`ifdef TIME_ALARM_EN
    logic [4:0] alarm_h_q, alarm_h_d;
    logic [5:0] alarm_m_q, alarm_m_d;
    logic       ticked_q, ticked_d;
    logic       ring_q, ring_d;
`endif

    always_comb begin
        hour24_d    = hour24_q;
        min_d       = min_q;
        sec_d       = sec_q;
        presc_d     = '0;
        day_pulse_d = 1'b0;
        tick        = 1'b0;
        step_up     = inc & ~dec;
        step_dn     = dec & ~inc;

        if (set_mode == 2'b00) begin
            if (presc_q == PRESC_MAX) begin
                tick = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        if (tick) begin
            day_pulse_d = (hour24_q == 5'd23) && (min_q == 6'd59) && (sec_q == 6'd59);
            if (sec_q == 6'd59) begin
                sec_d = 6'd0;
                if (min_q == 6'd59) begin
                    min_d    = 6'd0;
                    hour24_d = (hour24_q == 5'd23) ? 5'd0 : hour24_q + 5'd1;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end

        // Set edits touch only the selected field; no carries between fields.
        unique case (set_mode)
            2'b01: begin
                if (step_up) hour24_d = (hour24_q == 5'd23) ? 5'd0 : hour24_q + 5'd1;
                if (step_dn) hour24_d = (hour24_q == 5'd0) ? 5'd23 : hour24_q - 5'd1;
            end
            2'b10: begin
                if (step_up) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                if (step_dn) min_d = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
            end
            2'b11: begin
                if (step_up) sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
                if (step_dn) sec_d = (sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1;
            end
            default: ;
        endcase
    end

`ifdef TIME_ALARM_EN
    always_comb begin
        alarm_h_d = alarm_h_q;
        alarm_m_d = alarm_m_q;
        if (alarm_load) begin
            alarm_h_d = (alarm_hour24_in > 5'd23) ? 5'd23 : alarm_hour24_in;
            alarm_m_d = (alarm_minute_in > 6'd59) ? 6'd59 : alarm_minute_in;
        end
        ticked_d = tick;
        // Match is checked on the registered time the tick just produced, so set edits never ring.
        ring_d   = alarm_arm && (ring_q || (ticked_q && hour24_q == alarm_h_q &&
                                           min_q == alarm_m_q && sec_q == 6'd0));
    end

    always_ff @(posedge seconds_clk or negedge rst) begin
        if (!rst) begin
            alarm_h_q <= 5'd0;
            alarm_m_q <= 6'd0;
            ticked_q  <= 1'b0;
            ring_q    <= 1'b0;
        end else begin
            alarm_h_q <= alarm_h_d;
            alarm_m_q <= alarm_m_d;
            ticked_q  <= ticked_d;
            ring_q    <= ring_d;
        end
    end

    assign alarm_ring = ring_q;
`endif

    always_ff @(posedge seconds_clk or negedge rst) begin
        if (!rst) begin
            hour24_q    <= 5'(RESET_HOUR24);
            min_q       <= 6'(RESET_MINUTE);
            sec_q       <= 6'(RESET_SECOND);
            presc_q     <= '0;
            day_pulse_q <= 1'b0;
        end else begin
            hour24_q    <= hour24_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            presc_q     <= presc_d;
            day_pulse_q <= day_pulse_d;
        end
    end

    assign hour_mod12 = (hour24_q >= 5'd12) ? hour24_q - 5'd12 : hour24_q;
    assign hours      = mode_24h ? hour24_q : ((hour_mod12 == 5'd0) ? 5'd12 : hour_mod12);
    assign minutes    = min_q;
    assign seconds    = sec_q;
    assign pm         = (hour24_q >= 5'd12);
    assign day_pulse  = day_pulse_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Scoreboard bench for time_of_day_counter: two instances (1 tick/s from 23:59:59, 4 ticks/s
// from reset defaults); alarm checks are included when TIME_ALARM_EN is defined.
module tb_time_of_day_counter;

    logic       clk;
    logic       rst;
    logic       mode_24h;
    logic [1:0] s1, s4;
    logic       i1, d1, i4, d4;
    logic [4:0] hours1, hours4;
    logic [5:0] minutes1, minutes4, seconds1, seconds4;
    logic       pm1, pm4, dp1, dp4;
    logic       al_load, al_arm, ring1, ring4;
    logic [4:0] al_h;
    logic [5:0] al_m;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [18:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    time_of_day_counter #(
        .TICKS_PER_SEC(1), .RESET_HOUR24(23), .RESET_MINUTE(59), .RESET_SECOND(59)
    ) dut1 (
        .seconds_clk(clk), .rst(rst), .mode_24h(mode_24h),
        .set_mode(s1), .inc(i1), .dec(d1),
`ifdef TIME_ALARM_EN
        .alarm_load(al_load), .alarm_hour24_in(al_h), .alarm_minute_in(al_m),
        .alarm_arm(al_arm), .alarm_ring(ring1),
`endif
        .hours(hours1), .minutes(minutes1), .seconds(seconds1), .pm(pm1), .day_pulse(dp1)
    );

    time_of_day_counter #(
        .TICKS_PER_SEC(4), .RESET_HOUR24(0), .RESET_MINUTE(0), .RESET_SECOND(0)
    ) dut4 (
        .seconds_clk(clk), .rst(rst), .mode_24h(mode_24h),
        .set_mode(s4), .inc(i4), .dec(d4),
`ifdef TIME_ALARM_EN
        .alarm_load(1'b0), .alarm_hour24_in(5'd0), .alarm_minute_in(6'd0),
        .alarm_arm(1'b0), .alarm_ring(ring4),
`endif
        .hours(hours4), .minutes(minutes4), .seconds(seconds4), .pm(pm4), .day_pulse(dp4)
    );

`ifndef TIME_ALARM_EN
    assign ring1 = 1'b0;
    assign ring4 = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [18:0] pk(int h, int m, int s, int p, int dp);
        return {5'(h), 6'(m), 6'(s), 1'(p), 1'(dp)};
    endfunction

    function automatic int disp12(int h24);
        return (h24 % 12 == 0) ? 12 : h24 % 12;
    endfunction

    function automatic logic [18:0] observe(int sel);
        case (sel)
            0:       return {hours1, minutes1, seconds1, pm1, dp1};
            1:       return {hours4, minutes4, seconds4, pm4, dp4};
            default: return {18'd0, ring1};
        endcase
    endfunction

    task automatic check_val(string tag, logic [18:0] obs, logic [18:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s: %h", tag, obs);
        end
    endtask

    task automatic expect_out(string tag, int sel, logic [18:0] exp);
        sb_entry_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        sb_entry_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        drain();
    endtask

    initial begin
        rst = 1'b0; mode_24h = 1'b0;
        s1 = 2'b01; i1 = 1'b0; d1 = 1'b0;
        s4 = 2'b00; i4 = 1'b0; d4 = 1'b0;
        al_load = 1'b0; al_arm = 1'b0; al_h = 5'd0; al_m = 6'd0;

        repeat (2) @(negedge clk);
        expect_out("reset_defaults", 1, pk(12, 0, 0, 0, 0));
        expect_out("reset_235959", 0, pk(11, 59, 59, 1, 0));
        drain();
        rst = 1'b1;

        // Prescaler of 4: seconds advance every 4th cycle.
        for (int n = 1; n <= 10; n++) begin
            expect_out($sformatf("presc4_c%0d", n), 1, pk(12, 0, n / 4, 0, 0));
            cycle();
        end

        // Asynchronous reset mid-count, checked between clock edges.
        #2 rst = 1'b0;
        #1 expect_out("async_reset", 1, pk(12, 0, 0, 0, 0));
        drain();
        @(negedge clk);
        rst = 1'b1;

        // Two run cycles (presc=2), set mode, then resume: next advance 4 cycles later.
        for (int n = 0; n < 2; n++) begin
            expect_out("pre_set_run", 1, pk(12, 0, 0, 0, 0));
            cycle();
        end
        s4 = 2'b11;
        for (int n = 0; n < 3; n++) begin
            expect_out("set_frozen4", 1, pk(12, 0, 0, 0, 0));
            cycle();
        end
        s4 = 2'b00;
        for (int n = 1; n <= 4; n++) begin
            expect_out($sformatf("resume_c%0d", n), 1, pk(12, 0, (n == 4) ? 1 : 0, 0, 0));
            cycle();
        end
        s4 = 2'b01;

        // Day rollover on the 1 tick/s instance.
        s1 = 2'b00;
        expect_out("day_wrap", 0, pk(12, 0, 0, 0, 1));
        cycle();
        expect_out("day_pulse_once", 0, pk(12, 0, 1, 0, 0));
        cycle();
        s1 = 2'b01;

        // Walk to 11:59:59 through set mode.
        i1 = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            expect_out($sformatf("set_hour_%0d", n), 0, pk(n, 0, 1, 0, 0));
            cycle();
        end
        i1 = 1'b0;
        s1 = 2'b10; d1 = 1'b1;
        expect_out("min_dec_0", 0, pk(11, 59, 1, 0, 0));
        cycle();
        s1 = 2'b11;
        expect_out("sec_dec_1", 0, pk(11, 59, 0, 0, 0));
        cycle();
        expect_out("sec_dec_wrap", 0, pk(11, 59, 59, 0, 0));
        cycle();

        // Minute edits: wrap with no carry, inc+dec holds.
        s1 = 2'b10; d1 = 1'b0; i1 = 1'b1;
        expect_out("min_inc_wrap", 0, pk(11, 0, 59, 0, 0));
        cycle();
        i1 = 1'b0; d1 = 1'b1;
        expect_out("min_dec_wrap", 0, pk(11, 59, 59, 0, 0));
        cycle();
        i1 = 1'b1;
        expect_out("inc_dec_hold", 0, pk(11, 59, 59, 0, 0));
        cycle();
        i1 = 1'b0; d1 = 1'b0;

        // Noon and 12/24h decode.
        s1 = 2'b00;
        expect_out("noon_12h", 0, pk(12, 0, 0, 1, 0));
        cycle();
        s1 = 2'b01;
        mode_24h = 1'b1;
        #1 expect_out("noon_24h_same_cycle", 0, pk(12, 0, 0, 1, 0));
        drain();
        i1 = 1'b1;
        expect_out("h13_24h", 0, pk(13, 0, 0, 1, 0));
        cycle();
        i1 = 1'b0;
        mode_24h = 1'b0;
        #1 expect_out("h13_12h", 0, pk(1, 0, 0, 1, 0));
        drain();

        // Hour decrement down through 12 AM to 11 PM, then inc wraps to midnight.
        d1 = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            int h24;
            h24 = (13 - n + 24) % 24;
            expect_out($sformatf("hour_dec_%0d", h24), 0, pk(disp12(h24), 0, 0, (h24 >= 12) ? 1 : 0, 0));
            cycle();
        end
        d1 = 1'b0; i1 = 1'b1;
        expect_out("hour_inc_wrap", 0, pk(12, 0, 0, 0, 0));
        cycle();
        i1 = 1'b0;

`ifdef TIME_ALARM_EN
        al_load = 1'b1; al_h = 5'd7; al_m = 6'd30;
        expect_out("alarm_load", 2, 19'd0);
        cycle();
        al_load = 1'b0;
        i1 = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            expect_out("al_set_h", 0, pk(n, 0, 0, 0, 0));
            cycle();
        end
        s1 = 2'b10;
        for (int n = 1; n <= 29; n++) begin
            expect_out("al_set_m", 0, pk(7, n, 0, 0, 0));
            cycle();
        end
        i1 = 1'b0; d1 = 1'b1; s1 = 2'b11;
        for (int n = 1; n <= 2; n++) begin
            expect_out("al_set_s", 0, pk(7, 29, 60 - n, 0, 0));
            cycle();
        end
        d1 = 1'b0; al_arm = 1'b1; s1 = 2'b00;
        expect_out("al_072959", 0, pk(7, 29, 59, 0, 0));
        expect_out("al_ring_low0", 2, 19'd0);
        cycle();
        expect_out("al_073000", 0, pk(7, 30, 0, 0, 0));
        expect_out("al_ring_low1", 2, 19'd0);
        cycle();
        expect_out("al_ring_rise", 2, 19'd1);
        cycle();
        s1 = 2'b01;
        expect_out("al_ring_hold", 2, 19'd1);
        cycle();
        al_arm = 1'b0;
        expect_out("al_ring_clear", 2, 19'd0);
        cycle();
        s1 = 2'b11; d1 = 1'b1;
        expect_out("al_edit_073000", 0, pk(7, 30, 0, 0, 0));
        cycle();
        d1 = 1'b0; al_arm = 1'b1;
        for (int n = 0; n < 3; n++) begin
            expect_out("al_edit_no_ring", 2, 19'd0);
            cycle();
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
